// File: rtl/signal_playback.sv
// -----------------------------------------------------------------------------
// signal_playback
//   Runtime stimulus injection for JTAG debug. Software loads a pattern buffer
//   over the debug bus and arms the block. On a trigger match (or FORCE) the
//   pattern is replayed onto o_drive at a programmable rate. o_drive_en marks
//   when o_drive should override the functional signal.
//
// Ports
//   i_clk      system clock, single domain
//   i_rst      synchronous active-high reset
//   i_addr     bus register byte address
//   i_wdata    bus write data
//   i_read     bus read strobe (reads have no side effects)
//   i_write    bus write strobe, one cycle per write
//   o_rdata    combinational read data for i_addr
//   o_ready    always 1
//   i_trig_in  trigger compare source
//   o_drive    registered playback value
//   o_drive_en registered; 1 = o_drive valid
//   o_busy     registered; 1 while ARMED or PLAYING
// -----------------------------------------------------------------------------
module signal_playback #(
    parameter int BUFFER_DEPTH = 256,
    parameter int OUT_WIDTH    = 32,
    parameter int TRIG_WIDTH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_addr,
    input  logic [31:0]           i_wdata,
    input  logic                  i_read,
    input  logic                  i_write,
    output logic [31:0]           o_rdata,
    output logic                  o_ready,
    input  logic [TRIG_WIDTH-1:0] i_trig_in,
    output logic [OUT_WIDTH-1:0]  o_drive,
    output logic                  o_drive_en,
    output logic                  o_busy
);

    localparam int          AW       = $clog2(BUFFER_DEPTH);
    localparam logic [31:0] ID_VALUE = 32'h50B1_0001;
    localparam logic [AW:0] LEN_MAX  = (AW+1)'(BUFFER_DEPTH);

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h04;
    localparam logic [7:0] ADDR_CONTROL  = 8'h08;
    localparam logic [7:0] ADDR_TRIGGER  = 8'h0C;
    localparam logic [7:0] ADDR_MASK     = 8'h10;
    localparam logic [7:0] ADDR_BUF_ADDR = 8'h14;
    localparam logic [7:0] ADDR_BUF_DATA = 8'h18;
    localparam logic [7:0] ADDR_LENGTH   = 8'h1C;
    localparam logic [7:0] ADDR_DIVIDER  = 8'h20;
    localparam logic [7:0] ADDR_POSITION = 8'h24;
    localparam logic [7:0] ADDR_LOOPS    = 8'h28;

    // CONTROL bit positions
    localparam int C_ARM     = 0;
    localparam int C_FORCE   = 1;
    localparam int C_LOOP    = 2;
    localparam int C_HOLD    = 3;
    localparam int C_TRIG_EN = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PLAYING,
        S_DONE
    } state_t;

    // Bus-visible registers
    logic [4:0]            r_ctrl;
    logic [TRIG_WIDTH-1:0] r_trigger;
    logic [TRIG_WIDTH-1:0] r_mask;
    logic [AW-1:0]         r_buf_addr;
    logic [AW:0]           r_length;      // 1..BUFFER_DEPTH
    logic [15:0]           r_divider;
    logic [OUT_WIDTH-1:0]  r_mem [BUFFER_DEPTH];

    // Playback engine
    state_t                r_state;
    logic [AW-1:0]         r_position;
    logic [31:0]           r_loops;
    logic [15:0]           r_div_cnt;
    logic [OUT_WIDTH-1:0]  r_drive;
    logic                  r_drive_en;
    logic                  r_busy;

    logic                  w_wr_ctrl;
    logic                  w_wr_buf_data;
    logic                  w_match;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_hw_arm_clr;
    logic [AW:0]           w_len_wdata;
    logic                  w_unused;

    assign o_ready    = 1'b1;
    assign o_drive    = r_drive;
    assign o_drive_en = r_drive_en;
    assign o_busy     = r_busy;

    // Reads are pure address decode, so the read strobe carries no information.
    assign w_unused = i_read;

    assign w_wr_ctrl     = i_write && (i_addr == ADDR_CONTROL);
    assign w_wr_buf_data = i_write && (i_addr == ADDR_BUF_DATA);

    assign w_match = r_ctrl[C_TRIG_EN] &&
                     ((i_trig_in & r_mask) == (r_trigger & r_mask));

    // ">=" rather than "==" so a DIVIDER lowered mid-sample still advances on
    // the next compare instead of waiting for the counter to wrap.
    assign w_tick = (r_div_cnt >= r_divider);

    // ">=" also covers POSITION left beyond a LENGTH shrunk during playback.
    assign w_last = ({1'b0, r_position} >= (r_length - (AW+1)'(1)));

    // Hardware clears ARM exactly when a non-looping pass completes.
    assign w_hw_arm_clr = (r_state == S_PLAYING) && r_ctrl[C_ARM] && w_tick &&
                          w_last && !r_ctrl[C_LOOP];

    // LENGTH write saturation: 0 stores as 1, anything above depth stores depth.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_len_wdata = i_wdata[AW:0];
        if (i_wdata == 32'd0) begin
            w_len_wdata = (AW+1)'(1);
        end else if (i_wdata > 32'(BUFFER_DEPTH)) begin
            w_len_wdata = LEN_MAX;
        end
    end

    // Bus register file
    // NOTE: clocked state uses non-blocking (<=) so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl     <= '0;
            r_trigger  <= '0;
            r_mask     <= '1;
            r_buf_addr <= '0;
            r_length   <= LEN_MAX;
            r_divider  <= '0;
        end else begin
            // A software CONTROL write in the same cycle beats the hw ARM clear.
            if (w_wr_ctrl) begin
                r_ctrl <= i_wdata[4:0];
            end else if (w_hw_arm_clr) begin
                r_ctrl[C_ARM] <= 1'b0;
            end

            if (i_write && (i_addr == ADDR_TRIGGER)) begin
                r_trigger <= i_wdata[TRIG_WIDTH-1:0];
            end
            if (i_write && (i_addr == ADDR_MASK)) begin
                r_mask <= i_wdata[TRIG_WIDTH-1:0];
            end

            if (i_write && (i_addr == ADDR_BUF_ADDR)) begin
                r_buf_addr <= i_wdata[AW-1:0];
            end else if (w_wr_buf_data) begin
                r_buf_addr <= r_buf_addr + AW'(1);   // wraps mod depth
            end

            if (i_write && (i_addr == ADDR_LENGTH)) begin
                r_length <= w_len_wdata;
            end
            if (i_write && (i_addr == ADDR_DIVIDER)) begin
                r_divider <= i_wdata[15:0];
            end
        end
    end

    // Pattern buffer
    // NOTE: the buffer has no reset; software always loads it before use.
    always_ff @(posedge i_clk) begin
        if (w_wr_buf_data) begin
            r_mem[r_buf_addr] <= i_wdata[OUT_WIDTH-1:0];
        end
    end

    // Playback FSM with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_position <= '0;
            r_loops    <= '0;
            r_div_cnt  <= '0;
            r_drive    <= '0;
            r_drive_en <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ctrl[C_ARM]) begin
                        r_state <= S_ARMED;
                        r_loops <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_ARMED: begin
                    if (!r_ctrl[C_ARM]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_match || r_ctrl[C_FORCE]) begin
                        r_state    <= S_PLAYING;
                        r_drive    <= r_mem[0];
                        r_drive_en <= 1'b1;
                        r_position <= '0;
                        r_div_cnt  <= '0;
                    end
                end

                S_PLAYING: begin
                    if (!r_ctrl[C_ARM]) begin
                        // Software abort
                        r_state    <= S_IDLE;
                        r_drive    <= '0;
                        r_drive_en <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_tick) begin
                        r_div_cnt <= '0;
                        if (w_last) begin
                            if (r_loops != 32'hFFFF_FFFF) begin
                                r_loops <= r_loops + 32'd1;
                            end
                            if (r_ctrl[C_LOOP]) begin
                                r_position <= '0;
                                r_drive    <= r_mem[0];
                            end else begin
                                // o_drive keeps the last sample
                                r_state    <= S_DONE;
                                r_drive_en <= r_ctrl[C_HOLD];
                                r_busy     <= 1'b0;
                            end
                        end else begin
                            r_position <= r_position + AW'(1);
                            r_drive    <= r_mem[r_position + AW'(1)];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end

                S_DONE: begin
                    if (r_ctrl[C_ARM]) begin
                        r_state    <= S_ARMED;
                        r_loops    <= '0;
                        r_drive_en <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read mux
    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_ID:       o_rdata = ID_VALUE;
            ADDR_STATUS:   o_rdata = {28'b0, (r_loops != 32'd0), (r_state == S_DONE),
                                      (r_state == S_PLAYING), (r_state == S_ARMED)};
            ADDR_CONTROL:  o_rdata = {27'b0, r_ctrl};
            ADDR_TRIGGER:  o_rdata[TRIG_WIDTH-1:0] = r_trigger;
            ADDR_MASK:     o_rdata[TRIG_WIDTH-1:0] = r_mask;
            ADDR_BUF_ADDR: o_rdata[AW-1:0] = r_buf_addr;
            ADDR_BUF_DATA: o_rdata[OUT_WIDTH-1:0] = r_mem[r_buf_addr];
            ADDR_LENGTH:   o_rdata[AW:0] = r_length;
            ADDR_DIVIDER:  o_rdata[15:0] = r_divider;
            ADDR_POSITION: o_rdata[AW-1:0] = r_position;
            ADDR_LOOPS:    o_rdata = r_loops;
            default:       o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_signal_playback.sv
// -----------------------------------------------------------------------------
// tb_signal_playback
//   Self-checking bench for signal_playback. Expected playback streams are
//   built from the pattern contents with plain loops: each entry is held
//   DIVIDER+1 cycles, LENGTH entries per pass, preceded by one ARMED cycle.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_signal_playback;

    localparam int DEPTH = 256;

    localparam logic [7:0] A_ID       = 8'h00;
    localparam logic [7:0] A_STATUS   = 8'h04;
    localparam logic [7:0] A_CONTROL  = 8'h08;
    localparam logic [7:0] A_TRIGGER  = 8'h0C;
    localparam logic [7:0] A_MASK     = 8'h10;
    localparam logic [7:0] A_BUF_ADDR = 8'h14;
    localparam logic [7:0] A_BUF_DATA = 8'h18;
    localparam logic [7:0] A_LENGTH   = 8'h1C;
    localparam logic [7:0] A_DIVIDER  = 8'h20;
    localparam logic [7:0] A_POSITION = 8'h24;
    localparam logic [7:0] A_LOOPS    = 8'h28;

    localparam int AUX_NONE = 0;
    localparam int AUX_POS  = 1;
    localparam int AUX_LOOP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        read;
    logic        write;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] trig_in;
    logic [31:0] drive;
    logic        drive_en;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [DEPTH];

    typedef struct {
        logic        en;
        logic [31:0] drv;
        logic        chk_drv;
        logic        busy;
        logic        chk_aux;
        logic [31:0] aux;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    signal_playback #(
        .BUFFER_DEPTH (DEPTH),
        .OUT_WIDTH    (32),
        .TRIG_WIDTH   (32)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_read     (read),
        .i_write    (write),
        .o_rdata    (rdata),
        .o_ready    (ready),
        .i_trig_in  (trig_in),
        .o_drive    (drive),
        .o_drive_en (drive_en),
        .o_busy     (busy)
    );

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        read = 1'b1;
        #1;
        d    = rdata;
        read = 1'b0;
    endtask

    // Copy mem_model[0..n-1] into the DUT buffer starting at address 0.
    task automatic push_buffer(input int n);
        bus_write(A_BUF_ADDR, 32'd0);
        for (int i = 0; i < n; i++) bus_write(A_BUF_DATA, mem_model[i]);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) mem_model[i] = $urandom;
    endtask

    task automatic push_exp(input logic en, input logic [31:0] drv, input logic chk_drv,
                            input logic bsy, input logic chk_aux, input logic [31:0] aux);
        exp_t e;
        e.en = en; e.drv = drv; e.chk_drv = chk_drv;
        e.busy = bsy; e.chk_aux = chk_aux; e.aux = aux;
        exp_q.push_back(e);
    endtask

    // Reference model of one playback run.
    task automatic model_play(input int len, input int div, input int passes,
                              input bit loop_mode, input bit hold,
                              input bit with_armed, input int aux_kind);
        exp_q.delete();
        if (with_armed) push_exp(1'b0, 32'd0, 1'b0, 1'b1, aux_kind == AUX_LOOP, 32'd0);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < len; i++)
                for (int r = 0; r <= div; r++)
                    push_exp(1'b1, mem_model[i], 1'b1, 1'b1, aux_kind != AUX_NONE,
                             (aux_kind == AUX_POS) ? 32'(i) : 32'(p));
        if (!loop_mode)
            for (int k = 0; k < 3; k++)
                push_exp(hold, mem_model[len-1], hold, 1'b0, aux_kind == AUX_LOOP, 32'(passes));
    endtask

    // Walk exp_q one cycle per entry, with i_addr parked on a_aux.
    task automatic check_stream(input logic [7:0] a_aux, input string tag);
        addr = a_aux;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (drive_en !== exp_q[k].en) begin
                failures++;
                $display("FAIL %s[%0d] drive_en got=%0b want=%0b", tag, k, drive_en, exp_q[k].en);
            end
            checks++;
            if (busy !== exp_q[k].busy) begin
                failures++;
                $display("FAIL %s[%0d] busy got=%0b want=%0b", tag, k, busy, exp_q[k].busy);
            end
            if (exp_q[k].chk_drv) begin
                checks++;
                if (drive !== exp_q[k].drv) begin
                    failures++;
                    $display("FAIL %s[%0d] drive got=%h want=%h", tag, k, drive, exp_q[k].drv);
                end
            end
            if (exp_q[k].chk_aux) begin
                checks++;
                if (rdata !== exp_q[k].aux) begin
                    failures++;
                    $display("FAIL %s[%0d] reg%h got=%h want=%h", tag, k, a_aux, rdata, exp_q[k].aux);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0]  ra [11] = '{A_ID, A_STATUS, A_CONTROL, A_TRIGGER, A_MASK, A_BUF_ADDR,
                                 A_LENGTH, A_DIVIDER, A_POSITION, A_LOOPS, 8'h2C};
        logic [31:0] rv [11] = '{32'h50B10001, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0,
                                 32'd256, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        checks++;
        if ({drive_en, busy, drive} !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_outputs got en=%0b busy=%0b drive=%h want 0/0/0", drive_en, busy, drive);
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%0b want=1", ready);
        end
        for (int i = 0; i < 11; i++) begin
            bus_read(ra[i], d);
            checks++;
            if (d !== rv[i]) begin
                failures++;
                $display("FAIL reset_reg%h got=%h want=%h", ra[i], d, rv[i]);
            end
        end
    endtask

    task automatic test_registers();
        logic [31:0] lw [6];
        logic [31:0] lr [6];
        logic [31:0] d, t, m;
        int          rl;
        rl = $urandom_range(1, DEPTH);
        lw = '{32'd0, 32'd999, 32'd5, 32'd256, 32'd257, 32'(rl)};
        lr = '{32'd1, 32'd256, 32'd5, 32'd256, 32'd256, 32'(rl)};
        for (int i = 0; i < 6; i++) begin
            bus_write(A_LENGTH, lw[i]);
            bus_read(A_LENGTH, d);
            checks++;
            if (d !== lr[i]) begin
                failures++;
                $display("FAIL length_w%0d got=%0d want=%0d", lw[i], d, lr[i]);
            end
        end
        bus_write(A_DIVIDER, 32'h0001_2345);
        bus_read(A_DIVIDER, d);
        checks++;
        if (d !== 32'h2345) begin
            failures++;
            $display("FAIL divider_trunc got=%h want=%h", d, 32'h2345);
        end
        bus_write(A_DIVIDER, 32'd0);
        bus_write(A_BUF_ADDR, 32'h1FF);
        bus_read(A_BUF_ADDR, d);
        checks++;
        if (d !== 32'hFF) begin
            failures++;
            $display("FAIL buf_addr_trunc got=%h want=%h", d, 32'hFF);
        end
        t = $urandom;
        m = $urandom;
        bus_write(A_TRIGGER, t);
        bus_write(A_MASK, m);
        bus_read(A_TRIGGER, d);
        checks++;
        if (d !== t) begin
            failures++;
            $display("FAIL trigger_rw got=%h want=%h", d, t);
        end
        bus_read(A_MASK, d);
        checks++;
        if (d !== m) begin
            failures++;
            $display("FAIL mask_rw got=%h want=%h", d, m);
        end
        // Read-only and unmapped writes are ignored
        bus_write(A_ID, 32'h0);
        bus_write(A_POSITION, 32'h7);
        bus_write(8'h30, 32'hDEAD_BEEF);
        bus_read(A_ID, d);
        checks++;
        if (d !== 32'h50B10001) begin
            failures++;
            $display("FAIL id_ro got=%h want=%h", d, 32'h50B10001);
        end
        bus_read(A_POSITION, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL position_ro got=%h want=0", d);
        end
        bus_read(8'h30, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL unmapped_read got=%h want=0", d);
        end
    endtask

    task automatic test_buffer();
        logic [31:0] d, x, y;
        int          base;
        base = $urandom_range(0, DEPTH - 9);
        bus_write(A_BUF_ADDR, 32'(base));
        for (int i = 0; i < 8; i++) begin
            mem_model[base + i] = $urandom;
            bus_write(A_BUF_DATA, mem_model[base + i]);
        end
        bus_read(A_BUF_ADDR, d);
        checks++;
        if (d !== 32'(base + 8)) begin
            failures++;
            $display("FAIL buf_addr_incr got=%0d want=%0d", d, base + 8);
        end
        for (int i = 0; i < 8; i++) begin
            bus_write(A_BUF_ADDR, 32'(base + i));
            bus_read(A_BUF_DATA, d);
            checks++;
            if (d !== mem_model[base + i]) begin
                failures++;
                $display("FAIL buf_readback[%0d] got=%h want=%h", base + i, d, mem_model[base + i]);
            end
        end
        // BUF_DATA reads do not advance BUF_ADDR
        bus_read(A_BUF_DATA, d);
        bus_read(A_BUF_ADDR, d);
        checks++;
        if (d !== 32'(base + 7)) begin
            failures++;
            $display("FAIL buf_read_no_incr got=%0d want=%0d", d, base + 7);
        end
        // Wrap at the top of the buffer
        x = $urandom;
        y = $urandom;
        bus_write(A_BUF_ADDR, 32'(DEPTH - 1));
        bus_write(A_BUF_DATA, x);
        bus_write(A_BUF_DATA, y);
        bus_read(A_BUF_ADDR, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL buf_wrap_addr got=%0d want=1", d);
        end
        bus_write(A_BUF_ADDR, 32'(DEPTH - 1));
        bus_read(A_BUF_DATA, d);
        checks++;
        if (d !== x) begin
            failures++;
            $display("FAIL buf_wrap_top got=%h want=%h", d, x);
        end
        bus_write(A_BUF_ADDR, 32'd0);
        bus_read(A_BUF_DATA, d);
        checks++;
        if (d !== y) begin
            failures++;
            $display("FAIL buf_wrap_zero got=%h want=%h", d, y);
        end
    endtask

    task automatic test_single_pass();
        logic [31:0] d;
        int          len, div;
        for (int it = 0; it < 5; it++) begin
            if (it < 2) begin
                mem_model[0] = 32'h11; mem_model[1] = 32'h22; mem_model[2] = 32'h33;
                len = 3;
                div = (it == 0) ? 0 : 2;
            end else begin
                len = $urandom_range(1, 6);
                div = $urandom_range(0, 3);
                fill_random(len);
            end
            push_buffer(len);
            bus_write(A_LENGTH, 32'(len));
            bus_write(A_DIVIDER, 32'(div));
            bus_write(A_CONTROL, 32'h03);
            model_play(len, div, 1, 1'b0, 1'b0, 1'b1, AUX_POS);
            check_stream(A_POSITION, $sformatf("single%0d", it));
            bus_read(A_STATUS, d);
            checks++;
            if (d !== 32'h0C) begin
                failures++;
                $display("FAIL single%0d_status got=%h want=%h", it, d, 32'h0C);
            end
            bus_read(A_CONTROL, d);
            checks++;
            if (d !== 32'h02) begin
                failures++;
                $display("FAIL single%0d_control got=%h want=%h", it, d, 32'h02);
            end
            bus_read(A_LOOPS, d);
            checks++;
            if (d !== 32'd1) begin
                failures++;
                $display("FAIL single%0d_loops got=%0d want=1", it, d);
            end
        end
    endtask

    task automatic test_trigger();
        logic [31:0] d, t, m, hit, miss;
        int          len, div;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                t = 32'hA5; m = 32'hFF; hit = 32'h1A5; miss = 32'h0A4; div = 0;
            end else begin
                t    = $urandom;
                m    = $urandom | 32'd1;
                hit  = (t & m) | ($urandom & ~m);
                miss = hit ^ (m & (~m + 32'd1));
                div  = $urandom_range(0, 2);
            end
            len = $urandom_range(2, 5);
            fill_random(len);
            push_buffer(len);
            bus_write(A_LENGTH, 32'(len));
            bus_write(A_DIVIDER, 32'(div));
            bus_write(A_TRIGGER, t);
            bus_write(A_MASK, m);
            trig_in = miss;
            bus_write(A_CONTROL, 32'h11);
            exp_q.delete();
            for (int k = 0; k < 3; k++) push_exp(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1);
            check_stream(A_STATUS, $sformatf("trig%0d_wait", it));
            trig_in = hit;
            model_play(len, div, 1, 1'b0, 1'b0, 1'b0, AUX_POS);
            check_stream(A_POSITION, $sformatf("trig%0d_play", it));
        end
        // A matching input is ignored while TRIG_EN is clear
        bus_write(A_CONTROL, 32'h01);
        exp_q.delete();
        for (int k = 0; k < 5; k++) push_exp(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1);
        check_stream(A_STATUS, "trig_disabled");
        bus_write(A_CONTROL, 32'h00);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL disarm_idle got status=%h busy=%0b want status=0 busy=0", d, busy);
        end
        trig_in = 32'd0;
    endtask

    task automatic test_loop();
        logic [31:0] d;
        int          div;
        div = $urandom_range(0, 2);
        mem_model[0] = 32'h11;
        mem_model[1] = 32'h22;
        push_buffer(2);
        bus_write(A_LENGTH, 32'd2);
        bus_write(A_DIVIDER, 32'(div));
        bus_write(A_CONTROL, 32'h07);
        model_play(2, div, 3, 1'b1, 1'b0, 1'b1, AUX_LOOP);
        check_stream(A_LOOPS, "loop");
        // Abort by clearing ARM
        bus_write(A_CONTROL, 32'h04);
        @(negedge clk);
        checks++;
        if ({drive_en, busy, drive} !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL abort_outputs got en=%0b busy=%0b drive=%h want 0/0/0", drive_en, busy, drive);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL abort_status got=%h want=%h", d, 32'h08);
        end
        bus_read(A_LOOPS, d);
        checks++;
        if (d < 32'd3) begin
            failures++;
            $display("FAIL abort_loops got=%0d want>=3", d);
        end
    endtask

    task automatic test_hold_last();
        logic [31:0] d;
        fill_random(3);
        push_buffer(3);
        bus_write(A_LENGTH, 32'd3);
        bus_write(A_DIVIDER, 32'd1);
        bus_write(A_CONTROL, 32'h0B);
        model_play(3, 1, 1, 1'b0, 1'b1, 1'b1, AUX_LOOP);
        check_stream(A_LOOPS, "hold");
        bus_read(A_CONTROL, d);
        checks++;
        if (d !== 32'h0A) begin
            failures++;
            $display("FAIL hold_control got=%h want=%h", d, 32'h0A);
        end
        // Re-arm without FORCE: DONE -> ARMED drops drive_en
        bus_write(A_CONTROL, 32'h09);
        @(negedge clk);
        checks++;
        if (drive_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rearm_outputs got en=%0b busy=%0b want en=0 busy=1", drive_en, busy);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h01) begin
            failures++;
            $display("FAIL rearm_status got=%h want=%h", d, 32'h01);
        end
        bus_read(A_LOOPS, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL rearm_loops got=%0d want=0", d);
        end
        bus_write(A_CONTROL, 32'h00);
    endtask

    task automatic test_back_to_back();
        int lens [2] = '{1, DEPTH};
        for (int it = 0; it < 2; it++) begin
            fill_random(lens[it]);
            push_buffer(lens[it]);
            bus_write(A_LENGTH, 32'(lens[it]));
            bus_write(A_DIVIDER, 32'd0);
            bus_write(A_CONTROL, 32'h03);
            model_play(lens[it], 0, 1, 1'b0, 1'b0, 1'b1, AUX_POS);
            check_stream(A_POSITION, $sformatf("b2b_len%0d", lens[it]));
        end
    endtask

    task automatic test_reset_mid_play();
        logic [7:0]  ra [6] = '{A_CONTROL, A_LENGTH, A_MASK, A_LOOPS, A_POSITION, A_STATUS};
        logic [31:0] rv [6] = '{32'd0, 32'd256, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        fill_random(3);
        push_buffer(3);
        bus_write(A_LENGTH, 32'd3);
        bus_write(A_CONTROL, 32'h07);
        model_play(3, 0, 2, 1'b1, 1'b0, 1'b1, AUX_NONE);
        check_stream(A_POSITION, "prereset");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({drive_en, busy, drive} !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL midreset_outputs got en=%0b busy=%0b drive=%h want 0/0/0", drive_en, busy, drive);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(ra[i], d);
            checks++;
            if (d !== rv[i]) begin
                failures++;
                $display("FAIL midreset_reg%h got=%h want=%h", ra[i], d, rv[i]);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        addr    = 8'h00;
        wdata   = 32'd0;
        read    = 1'b0;
        write   = 1'b0;
        trig_in = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_registers();
        test_buffer();
        test_single_pass();
        test_trigger();
        test_loop();
        test_hold_last();
        test_back_to_back();
        test_reset_mid_play();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
